// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and widths for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } seq_state_t;

  localparam int RETRY_W = 4;

  // Width of the shared per-state cycle counter. The counter only ever has to
  // reach (largest terminal count - 1), so $clog2 of the largest count is enough.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with async active-low reset
//
// Ports:
//   clk   - destination clock
//   rst   - asynchronous active-low reset, clears both stages
//   d     - asynchronous input bits
//   q     - synchronized output, two destination cycles behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL reset/lock sequencer with staggered domain reset release
//
// Optional feature macro: PLL_LOCK_SEQ_LOSS_CNT_EN (adds lock_loss_cnt).
//
// Ports:
//   clk           - board input clock, the only clock
//   rst           - asynchronous active-low reset
//   pll_locked    - PLL lock indicator, asynchronous to clk
//   restart       - single-cycle pulse, leaves FAIL and starts a new sequence
//   pll_areset    - PLL reset, active-high
//   rst_n_out     - per-domain active-low resets, released in staggered order
//   ready         - high only in RUN
//   fail          - high only in FAIL
//   retry_cnt     - failed lock attempts since last lock, restart or rst
//   lock_loss_cnt - (optional) saturating count of lock losses in RELEASE/RUN
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 65536,
  parameter int STABLE_CYC  = 1024,
  parameter int STAGGER_CYC = 8,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_areset,
  output logic [N_DOM-1:0]   rst_n_out,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]         lock_loss_cnt
`endif
);

  localparam int REL_CYC = (N_DOM - 1) * STAGGER_CYC + 1;
  localparam int CNT_W   = cnt_width(HOLD_CYC, TIMEOUT_CYC, STABLE_CYC, REL_CYC);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   REL_LAST     = CNT_W'(REL_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  logic locked_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  seq_state_t         state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               pll_areset_d, ready_d, fail_d;
  logic [N_DOM-1:0]   rst_n_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HOLD;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_areset <= 1'b1;
      rst_n_out  <= '0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_d;
      retry_cnt  <= retry_d;
      pll_areset <= pll_areset_d;
      rst_n_out  <= rst_n_d;
      ready      <= ready_d;
      fail       <= fail_d;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    retry_d    = retry_cnt;
    case (state)
      HOLD: begin
        if (cnt == HOLD_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is checked first so a lock seen on the timeout cycle wins.
        if (locked_s) begin
          next_state = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_d    = retry_cnt + 1'b1;
          next_state = (retry_d == RETRY_LIMIT) ? FAIL : HOLD;
        end
      end
      STABLE: begin
        if (!locked_s)                next_state = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  next_state = RELEASE;
      end
      RELEASE: begin
        if (!locked_s) begin
          next_state = HOLD;
        end else if (cnt == REL_LAST) begin
          next_state = RUN;
          retry_d    = '0;
        end
      end
      RUN: begin
        if (!locked_s) next_state = HOLD;
      end
      FAIL: begin
        if (restart) begin
          next_state = HOLD;
          retry_d    = '0;
        end
      end
      default: next_state = HOLD;
    endcase
  end

  // Counter restarts on every state change; RUN and FAIL have no terminal
  // count, so the counter parks there instead of wrapping.
  always_comb begin
    cnt_d = cnt;
    if (next_state != state)
      cnt_d = '0;
    else if (state != RUN && state != FAIL)
      cnt_d = cnt + 1'b1;
  end

  // Outputs are registered from the next state so they track the state
  // register exactly; domain i releases once the RELEASE counter reaches
  // i*STAGGER_CYC, which makes bit 0 high on the first RELEASE cycle.
  always_comb begin
    pll_areset_d = (next_state == HOLD) || (next_state == FAIL);
    ready_d      = (next_state == RUN);
    fail_d       = (next_state == FAIL);
    rst_n_d      = '0;
    for (int i = 0; i < N_DOM; i++) begin
      if (next_state == RUN)
        rst_n_d[i] = 1'b1;
      else if (next_state == RELEASE && int'(cnt_d) >= i * STAGGER_CYC)
        rst_n_d[i] = 1'b1;
    end
  end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_loss_cnt <= '0;
    end else if ((state == RELEASE || state == RUN) && !locked_s &&
                 lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - directed self-checking bench for pll_lock_seq
module tb_pll_lock_seq;

  localparam int N_DOM = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pll_locked = 1'b0;
  logic             restart = 1'b0;
  logic             pll_areset;
  logic [N_DOM-1:0] rst_n_out;
  logic             ready;
  logic             fail;
  logic [3:0]       retry_cnt;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic [7:0]       lock_loss_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pll_lock_seq #(
    .N_DOM(N_DOM), .HOLD_CYC(4), .TIMEOUT_CYC(32), .STABLE_CYC(8),
    .STAGGER_CYC(3), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
    .pll_areset(pll_areset), .rst_n_out(rst_n_out), .ready(ready),
    .fail(fail), .retry_cnt(retry_cnt)
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after an edge with rst released; next edge is E1.
  task automatic do_reset();
    rst = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick();
    n_cmp++; if (pll_areset !== 1'b1) begin n_fail++; $display("FAIL reset_areset: got %b expected 1", pll_areset); end
    n_cmp++; if (rst_n_out !== 4'b0000) begin n_fail++; $display("FAIL reset_rst_n: got %b expected 0000", rst_n_out); end
    n_cmp++; if (ready !== 1'b0 || fail !== 1'b0) begin n_fail++; $display("FAIL reset_ready_fail: got %b%b expected 00", ready, fail); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
  endtask

  // Leaves the DUT in RUN with pll_locked=1.
  task automatic test_nominal();
    int n;
    do_reset();
    n = 0;
    do begin tick(); n++; end while (pll_areset === 1'b1 && n < 20);
    n_cmp++; if (n != 4) begin n_fail++; $display("FAIL nom_hold_len: got %0d expected 4", n); end
    repeat (10) tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    n_cmp++; if (rst_n_out !== 4'b0000) begin n_fail++; $display("FAIL nom_pre_release: got %b expected 0000", rst_n_out); end
    tick();
    n_cmp++; if (rst_n_out !== 4'b0001) begin n_fail++; $display("FAIL nom_rel0: got %b expected 0001", rst_n_out); end
    repeat (3) tick();
    n_cmp++; if (rst_n_out !== 4'b0011) begin n_fail++; $display("FAIL nom_rel1: got %b expected 0011", rst_n_out); end
    repeat (3) tick();
    n_cmp++; if (rst_n_out !== 4'b0111) begin n_fail++; $display("FAIL nom_rel2: got %b expected 0111", rst_n_out); end
    repeat (3) tick();
    n_cmp++; if (rst_n_out !== 4'b1111 || ready !== 1'b0) begin n_fail++; $display("FAIL nom_rel3: got %b ready %b expected 1111 ready 0", rst_n_out, ready); end
    tick();
    n_cmp++; if (ready !== 1'b1 || retry_cnt !== 4'd0 || pll_areset !== 1'b0) begin n_fail++; $display("FAIL nom_run: got ready %b retry %0d areset %b expected 1 0 0", ready, retry_cnt, pll_areset); end
  endtask

  task automatic test_lock_loss_run();
    pll_locked = 1'b0;
    tick(); tick();
    n_cmp++; if (rst_n_out !== 4'b1111 || ready !== 1'b1) begin n_fail++; $display("FAIL loss_early: got %b ready %b expected 1111 ready 1", rst_n_out, ready); end
    tick();
    n_cmp++; if (rst_n_out !== 4'b0000 || ready !== 1'b0 || pll_areset !== 1'b1) begin n_fail++; $display("FAIL loss_drop: got %b ready %b areset %b expected 0000 0 1", rst_n_out, ready, pll_areset); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL loss_retry: got %0d expected 0", retry_cnt); end
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_cnt: got %0d expected 1", lock_loss_cnt); end
`endif
  endtask

  task automatic test_glitch_stable();
    do_reset();
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat (6) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    n_cmp++; if (rst_n_out !== 4'b0000) begin n_fail++; $display("FAIL glitch_requal: got %b expected 0000", rst_n_out); end
    tick();
    n_cmp++; if (rst_n_out !== 4'b0001 || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL glitch_release: got %b retry %0d expected 0001 0", rst_n_out, retry_cnt); end
  endtask

  task automatic test_no_lock();
    do_reset();
    repeat (35) tick();
    n_cmp++; if (pll_areset !== 1'b0 || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL nolock_wait1: got areset %b retry %0d expected 0 0", pll_areset, retry_cnt); end
    tick();
    n_cmp++; if (pll_areset !== 1'b1 || retry_cnt !== 4'd1) begin n_fail++; $display("FAIL nolock_to1: got areset %b retry %0d expected 1 1", pll_areset, retry_cnt); end
    repeat (14) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++; if (pll_areset !== 1'b0 || retry_cnt !== 4'd1) begin n_fail++; $display("FAIL nolock_restart_ignored: got areset %b retry %0d expected 0 1", pll_areset, retry_cnt); end
    repeat (56) tick();
    n_cmp++; if (fail !== 1'b0 || retry_cnt !== 4'd2) begin n_fail++; $display("FAIL nolock_pre_fail: got fail %b retry %0d expected 0 2", fail, retry_cnt); end
    tick();
    n_cmp++; if (fail !== 1'b1 || retry_cnt !== 4'd3 || pll_areset !== 1'b1) begin n_fail++; $display("FAIL nolock_fail: got fail %b retry %0d areset %b expected 1 3 1", fail, retry_cnt, pll_areset); end
    repeat (5) tick();
    n_cmp++; if (fail !== 1'b1 || pll_areset !== 1'b1 || rst_n_out !== 4'b0000) begin n_fail++; $display("FAIL nolock_fail_hold: got fail %b areset %b rst_n %b expected 1 1 0000", fail, pll_areset, rst_n_out); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++; if (fail !== 1'b0 || retry_cnt !== 4'd0 || pll_areset !== 1'b1) begin n_fail++; $display("FAIL nolock_restart: got fail %b retry %0d areset %b expected 0 0 1", fail, retry_cnt, pll_areset); end
    repeat (4) tick();
    n_cmp++; if (pll_areset !== 1'b0) begin n_fail++; $display("FAIL nolock_new_hold: got %b expected 0", pll_areset); end
  endtask

  task automatic test_async_reset_release();
    do_reset();
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat (14) tick();
    n_cmp++; if (rst_n_out !== 4'b0011) begin n_fail++; $display("FAIL arst_setup: got %b expected 0011", rst_n_out); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (pll_areset !== 1'b1 || rst_n_out !== 4'b0000) begin n_fail++; $display("FAIL arst_immediate: got areset %b rst_n %b expected 1 0000", pll_areset, rst_n_out); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_lock_at_timeout();
    do_reset();
    repeat (33) tick();
    pll_locked = 1'b1;
    repeat (3) tick();
    n_cmp++; if (pll_areset !== 1'b0 || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL edge_lock_wins: got areset %b retry %0d expected 0 0", pll_areset, retry_cnt); end
    repeat (7) tick();
    n_cmp++; if (rst_n_out !== 4'b0000) begin n_fail++; $display("FAIL edge_stable: got %b expected 0000", rst_n_out); end
    tick();
    n_cmp++; if (rst_n_out !== 4'b0001 || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL edge_release: got %b retry %0d expected 0001 0", rst_n_out, retry_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_run();
    test_glitch_stable();
    test_no_lock();
    test_async_reset_release();
    test_lock_at_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
Name: pll_lock_seq

Overview:
- Sequences the clock-generation PLL.
- Drives the PLL async reset and qualifies its lock output.
- Releases per-domain active-low resets to downstream clients, e.g. the four LED channels, in staggered order.
- Handles lock loss, lock timeout, retry and a terminal fail state. Runs on the board input clock, not on any PLL output.

Parameters:
- N_DOM, 4: number of downstream reset domains.
- HOLD_CYC, 16: cycles pll_areset is held high per attempt (>=1).
- TIMEOUT_CYC, 65536: cycles allowed in WAIT_LOCK before the attempt fails.
- STABLE_CYC, 1024: consecutive synchronized-lock cycles needed to qualify lock.
- STAGGER_CYC, 8: cycles between successive domain reset releases (>=1).
- MAX_RETRY, 3: failed attempts tolerated before FAIL; range 1..15.

Ports:
- clk, in, 1: board input clock; the only clock.
- rst, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL lock output, asynchronous to clk.
- restart, in, 1: single-cycle pulse; leaves FAIL and starts a new sequence.
- pll_areset, out, 1: PLL async reset, active-high.
- rst_n_out, out, N_DOM: per-domain reset, active-low; 1 = domain running.
- ready, out, 1: high only in RUN.
- fail, out, 1: high only in FAIL.
- retry_cnt, out, 4: failed attempts since last successful lock, restart or rst.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=HOLD, pll_areset=1, rst_n_out=0, ready=0, fail=0, retry_cnt=0.
  - Counters and synchronizer flops cleared.
- pll_locked passes a 2-flop synchronizer to give locked_s. The input-to-locked_s latency is 2 cycles.
- All outputs are registered. A state change appears on outputs in the cycle after the deciding edge.
- A single cycle counter `cnt` is cleared on every state entry.
- HOLD:
  - pll_areset=1.
  - After HOLD_CYC cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_areset=0.
  - If locked_s=1, go to STABLE.
  - Otherwise, when cnt reaches TIMEOUT_CYC-1, retry_cnt increments. If the new value equals MAX_RETRY, go to FAIL; else go to HOLD.
  - If locked_s=1 and timeout occur in the same cycle, lock wins.
- STABLE:
  - Requires locked_s=1 for STABLE_CYC consecutive cycles, then go to RELEASE.
  - Any locked_s=0 returns to WAIT_LOCK with cnt restarted. This is not counted as a retry.
  - The timeout is not re-armed from the earlier WAIT_LOCK time.
- RELEASE:
  - rst_n_out[i] goes high i*STAGGER_CYC cycles after RELEASE entry; bit 0 releases on the first RELEASE cycle.
  - Once a bit is released, it stays high.
  - After bit N_DOM-1 releases, go to RUN and clear retry_cnt.
- RUN:
  - ready=1; all rst_n_out=1.
  - On locked_s=0 in RELEASE or RUN: all rst_n_out=0 and ready=0 on the next cycle, then go to HOLD.
  - This lock loss does not increment retry_cnt.
- FAIL:
  - pll_areset=1, rst_n_out=0, fail=1.
  - Held until restart=1 or rst.
  - restart moves to HOLD and clears retry_cnt and fail. restart is ignored in all other states.
- Counter widths come from $clog2 of the largest cycle parameter. There is no wrap-around within any state.
- rst asserted mid-sequence forces the reset values immediately, including asserting pll_areset asynchronously.

Optional Feature:
- Macro: PLL_LOCK_SEQ_LOSS_CNT_EN.
- When defined: adds output lock_loss_cnt [7:0].
  - Increments on each lock loss detected in RELEASE or RUN.
  - Saturates at 255.
  - Cleared only by rst.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum: HOLD, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL;
  - the retry_cnt width constant.
- One sub-module, sync_2ff: a parameterized-width 2-flop synchronizer with async active-low reset. It produces locked_s.

Test Plan (bench parameters HOLD_CYC=4, TIMEOUT_CYC=32, STABLE_CYC=8, STAGGER_CYC=3, MAX_RETRY=3, N_DOM=4):
- Nominal lock:
  - Stimulus: release rst; raise pll_locked 10 cycles after pll_areset falls.
  - Response: pll_areset high 4 cycles; rst_n_out releases one bit every 3 cycles (0001, 0011, 0111, 1111); ready=1; retry_cnt=0.
- Lock glitch in STABLE:
  - Stimulus: drop pll_locked for 1 cycle 5 cycles into STABLE.
  - Response: return to WAIT_LOCK; re-qualify over 8 full cycles; retry_cnt unchanged.
- No lock:
  - Stimulus: hold pll_locked=0.
  - Response: three HOLD/WAIT_LOCK attempts of 4+32 cycles each; retry_cnt 1, 2, 3; then fail=1 with pll_areset held high.
  - Follow-up: a restart pulse gives fail=0, retry_cnt=0 and a new HOLD.
- Lock loss in RUN:
  - Stimulus: drop pll_locked.
  - Response: rst_n_out=0000 and ready=0 within 3 cycles of the input edge (2-cycle sync plus 1); pll_areset reasserts; lock_loss_cnt=1 when the macro is defined.
- Async reset mid-RELEASE:
  - Stimulus: assert rst with rst_n_out=0011.
  - Response: outputs immediately at reset values, i.e. pll_areset=1 and rst_n_out=0000.
- Lock at the timeout cycle:
  - Stimulus: locked_s rises exactly at cnt=31.
  - Response: enter STABLE; retry_cnt not incremented.
